sa_result_drain: RTL and testbench

//  Read-side counterpart of the systolic array load path. The load path writes operand rows via IDX/DIN_*; this block drains the results.
//  On START (issued the cycle matmul begins, i.e. WRITE deasserts), it waits a fixed settle time, then snapshots the full 8x8 Y_rc result grid.
//  It then streams the grid out one row per beat over a valid/ready interface to the host/AXI side.

---
 rtl/sa_result_drain_pkg.sv | 17 +
 rtl/sa_result_drain_if.sv | 27 ++
 rtl/sa_result_drain_row_buffer.sv | 25 ++
 rtl/sa_result_drain.sv | 89 ++++++++
 tb/tb_sa_result_drain.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_result_drain_pkg.sv
// Shared constants and types for the systolic-array result drain path.
package sa_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned DW    = 16;
    localparam int unsigned ROW_W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STREAM
    } drain_state_t;

    typedef logic [ROW_W-1:0] row_idx_t;
    typedef logic [N*DW-1:0]  row_word_t;

endpackage

// File: rtl/sa_result_drain_if.sv
// Row-per-beat valid/ready result stream from the drain to its consumer.
interface sa_result_drain_if;
    import sa_pkg::*;

    row_word_t OUT_DATA;
    row_idx_t  OUT_ROW;
    logic      OUT_VALID;
    logic      OUT_READY;
    logic      OUT_LAST;

    modport master (
        output OUT_DATA,
        output OUT_ROW,
        output OUT_VALID,
        output OUT_LAST,
        input  OUT_READY
    );

    modport slave (
        input  OUT_DATA,
        input  OUT_ROW,
        input  OUT_VALID,
        input  OUT_LAST,
        output OUT_READY
    );

endinterface

// File: rtl/sa_result_drain_row_buffer.sv
// N x N*DW snapshot register bank; parallel capture, combinational row read.
module sa_row_buffer
    import sa_pkg::*;
(
    input  logic                clk,
    input  logic                capture,
    input  logic [N*N*DW-1:0]   y_flat,
    input  row_idx_t            row,
    output row_word_t           row_data
);

    // Row r of Y_FLAT already occupies [r*N*DW +: N*DW], so the flat bus maps straight onto rows.
    logic [N-1:0][N*DW-1:0] mem;

    always_ff @(posedge clk) begin
        if (capture) begin
            mem <= y_flat;
        end
    end

    always_comb begin
        row_data = mem[row];
    end

endmodule

// File: rtl/sa_result_drain.sv
// Waits a settle time after START, snapshots the result grid, then streams it one row per beat.
module sa_result_drain
    import sa_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 24
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                START,
    input  logic [N*N*DW-1:0]   Y_FLAT,
    sa_result_drain_if.master   drain,
    output logic                BUSY,
    output logic                DONE
);

    drain_state_t state;
    logic [7:0]   cnt;
    row_idx_t     row;
    logic         valid;
    logic         last;
    logic         capture;
    row_word_t    row_data;

    assign capture = (state == WAIT) && (cnt == '0);

    sa_row_buffer u_buf (
        .clk      (CLK),
        .capture  (capture),
        .y_flat   (Y_FLAT),
        .row      (row),
        .row_data (row_data)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
            row   <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        state <= WAIT;
                        cnt   <= 8'(SETTLE_CYCLES - 1);
                        BUSY  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= STREAM;
                        row   <= '0;
                        valid <= 1'b1;
                        last  <= (N == 1);
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                STREAM: begin
                    if (valid && drain.OUT_READY) begin
                        if (last) begin
                            state <= IDLE;
                            valid <= 1'b0;
                            last  <= 1'b0;
                            row   <= '0;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end else begin
                            row  <= row + 1'b1;
                            last <= (row == row_idx_t'(N - 2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data is gated so the uninitialised buffer never reaches the port outside STREAM.
    assign drain.OUT_DATA  = valid ? row_data : '0;
    assign drain.OUT_ROW   = row;
    assign drain.OUT_VALID = valid;
    assign drain.OUT_LAST  = last;

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain: timing, backpressure, snapshot, START filtering, abort.
module tb_sa_result_drain;
    import sa_pkg::*;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              START;
    logic              START1;
    logic [N*N*DW-1:0] Y_FLAT;
    logic              BUSY, DONE, BUSY1, DONE1;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] grid [N][N];

    sa_result_drain_if bus ();
    sa_result_drain_if bus1 ();

    sa_result_drain #(.SETTLE_CYCLES(24)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .Y_FLAT (Y_FLAT),
        .drain  (bus),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    sa_result_drain #(.SETTLE_CYCLES(1)) dut1 (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START1),
        .Y_FLAT (Y_FLAT),
        .drain  (bus1),
        .BUSY   (BUSY1),
        .DONE   (DONE1)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input row_word_t obs, input row_word_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // mode 0: r*8+c, mode 1: constant k, mode 2: 0x3000 + r*256 + c*17
    task automatic set_grid(input int mode, input logic [DW-1:0] k);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (mode)
                    0:       grid[r][c] = DW'(r * 8 + c);
                    1:       grid[r][c] = k;
                    default: grid[r][c] = DW'(16'h3000 + r * 256 + c * 17);
                endcase
                Y_FLAT[(r*N+c)*DW +: DW] = grid[r][c];
            end
        end
    endtask

    function automatic row_word_t exp_row(input int r);
        row_word_t v;
        for (int c = 0; c < N; c++) v[c*DW +: DW] = grid[r][c];
        return v;
    endfunction

    task automatic start_drain();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    // Called just after E0; leaves the bench just after E0+24 with row 0 presented.
    task automatic wait_capture(input string tag);
        repeat (23) tick();
        check({tag, "_valid_e23"}, row_word_t'(bus.OUT_VALID), row_word_t'(0));
        check({tag, "_busy_e23"}, row_word_t'(BUSY), row_word_t'(1));
        tick();
        check({tag, "_valid_e24"}, row_word_t'(bus.OUT_VALID), row_word_t'(1));
    endtask

    task automatic stream_full(input string tag);
        for (int r = 0; r < N; r++) begin
            check($sformatf("%s_row%0d_idx", tag, r), row_word_t'(bus.OUT_ROW), row_word_t'(r));
            check($sformatf("%s_row%0d_data", tag, r), bus.OUT_DATA, exp_row(r));
            check($sformatf("%s_row%0d_last", tag, r), row_word_t'(bus.OUT_LAST), row_word_t'(r == N - 1));
            tick();
        end
        check({tag, "_valid_end"}, row_word_t'(bus.OUT_VALID), row_word_t'(0));
        check({tag, "_done"}, row_word_t'(DONE), row_word_t'(1));
        check({tag, "_busy_end"}, row_word_t'(BUSY), row_word_t'(0));
    endtask

    initial begin
        logic      pat [6];
        row_word_t pdata;
        row_idx_t  prow;
        logic      stalled;
        logic      done_seen;
        int        beats;

        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        RST_N = 1'b0;
        START = 1'b0;
        START1 = 1'b0;
        bus.OUT_READY = 1'b1;
        bus1.OUT_READY = 1'b1;
        set_grid(0, '0);

        // Reset state
        #2;
        check("rst_valid", row_word_t'(bus.OUT_VALID), row_word_t'(0));
        check("rst_data", bus.OUT_DATA, row_word_t'(0));
        check("rst_busy", row_word_t'(BUSY), row_word_t'(0));
        check("rst_done", row_word_t'(DONE), row_word_t'(0));
        check("rst_row", row_word_t'(bus.OUT_ROW), row_word_t'(0));
        #10 RST_N = 1'b1;
        tick();

        // Basic drain, READY held high
        start_drain();
        repeat (23) tick();
        check("basic_valid_e23", row_word_t'(bus.OUT_VALID), row_word_t'(0));
        tick();
        check("basic_valid_e24", row_word_t'(bus.OUT_VALID), row_word_t'(1));
        for (int r = 0; r < N; r++) begin
            check($sformatf("basic_row%0d_idx", r), row_word_t'(bus.OUT_ROW), row_word_t'(r));
            check($sformatf("basic_row%0d_data", r), bus.OUT_DATA, exp_row(r));
            check($sformatf("basic_row%0d_last", r), row_word_t'(bus.OUT_LAST), row_word_t'(r == N - 1));
            if (r == 3) check("basic_r3w5", row_word_t'(bus.OUT_DATA[5*DW +: DW]), row_word_t'(29));
            tick();
        end
        check("basic_valid_end", row_word_t'(bus.OUT_VALID), row_word_t'(0));
        check("basic_done", row_word_t'(DONE), row_word_t'(1));
        tick();
        check("basic_done_pulse", row_word_t'(DONE), row_word_t'(0));
        check("basic_busy_idle", row_word_t'(BUSY), row_word_t'(0));

        // Backpressure
        set_grid(2, '0);
        start_drain();
        repeat (23) tick();
        beats = 0;
        done_seen = 1'b0;
        for (int k = 0; k < 100 && !done_seen; k++) begin
            bus.OUT_READY = pat[k % 6];
            #1;
            stalled = bus.OUT_VALID && !bus.OUT_READY;
            pdata = bus.OUT_DATA;
            prow = bus.OUT_ROW;
            if (bus.OUT_VALID && bus.OUT_READY) begin
                check($sformatf("bp_beat%0d_idx", beats), row_word_t'(bus.OUT_ROW), row_word_t'(beats));
                check($sformatf("bp_beat%0d_data", beats), bus.OUT_DATA, exp_row(beats));
                beats++;
            end
            tick();
            if (stalled) begin
                check("bp_stall_valid", row_word_t'(bus.OUT_VALID), row_word_t'(1));
                check("bp_stall_data", bus.OUT_DATA, pdata);
                check("bp_stall_row", row_word_t'(bus.OUT_ROW), row_word_t'(prow));
            end
            if (DONE) done_seen = 1'b1;
        end
        check("bp_beats", row_word_t'(beats), row_word_t'(8));
        check("bp_done_seen", row_word_t'(done_seen), row_word_t'(1));
        bus.OUT_READY = 1'b1;
        tick();

        // Snapshot isolation
        set_grid(1, 16'h0001);
        start_drain();
        wait_capture("snap");
        Y_FLAT = '1;
        stream_full("snap");
        tick();

        // START during WAIT and STREAM ignored; START held into DONE cycle accepted
        set_grid(0, '0);
        start_drain();
        repeat (5) tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (17) tick();
        check("ign_valid_e23", row_word_t'(bus.OUT_VALID), row_word_t'(0));
        tick();
        check("ign_valid_e24", row_word_t'(bus.OUT_VALID), row_word_t'(1));
        for (int r = 0; r < N; r++) begin
            check($sformatf("ign_row%0d_idx", r), row_word_t'(bus.OUT_ROW), row_word_t'(r));
            check($sformatf("ign_row%0d_done", r), row_word_t'(DONE), row_word_t'(0));
            if (r == 2) START = 1'b1;
            if (r == 3) START = 1'b0;
            if (r == N - 1) START = 1'b1;
            tick();
        end
        check("ign_done", row_word_t'(DONE), row_word_t'(1));
        check("ign_busy_done", row_word_t'(BUSY), row_word_t'(0));
        tick();
        START = 1'b0;
        check("restart_busy", row_word_t'(BUSY), row_word_t'(1));
        check("restart_done_clr", row_word_t'(DONE), row_word_t'(0));
        wait_capture("restart");
        stream_full("restart");
        tick();

        // Abort mid-stream then fresh capture
        set_grid(2, '0);
        start_drain();
        wait_capture("abort");
        repeat (5) tick();
        check("abort_row5", row_word_t'(bus.OUT_ROW), row_word_t'(5));
        #2 RST_N = 1'b0;
        #1;
        check("abort_valid", row_word_t'(bus.OUT_VALID), row_word_t'(0));
        check("abort_data", bus.OUT_DATA, row_word_t'(0));
        check("abort_busy", row_word_t'(BUSY), row_word_t'(0));
        check("abort_done", row_word_t'(DONE), row_word_t'(0));
        check("abort_row", row_word_t'(bus.OUT_ROW), row_word_t'(0));
        #1 RST_N = 1'b1;
        tick();
        set_grid(0, '0);
        start_drain();
        wait_capture("fresh");
        stream_full("fresh");
        tick();

        // SETTLE_CYCLES = 1 instance
        set_grid(2, '0);
        START1 = 1'b1;
        tick();
        START1 = 1'b0;
        check("s1_valid_e0", row_word_t'(bus1.OUT_VALID), row_word_t'(0));
        check("s1_busy_e0", row_word_t'(BUSY1), row_word_t'(1));
        tick();
        check("s1_valid_e1", row_word_t'(bus1.OUT_VALID), row_word_t'(1));
        for (int r = 0; r < N; r++) begin
            check($sformatf("s1_row%0d_idx", r), row_word_t'(bus1.OUT_ROW), row_word_t'(r));
            check($sformatf("s1_row%0d_data", r), bus1.OUT_DATA, exp_row(r));
            tick();
        end
        check("s1_done", row_word_t'(DONE1), row_word_t'(1));
        check("s1_valid_end", row_word_t'(bus1.OUT_VALID), row_word_t'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
